// File: rtl/btb_assoc_ctrl.sv
// N-way set-associative branch target buffer: lookup, counter update, true-LRU replacement and flush sweep.
// Latency: prediction registered one cycle after lk_valid; updates take effect at the next edge; flush busies SETS cycles.
// Backpressure: none; updates arriving during a flush (or with a flush request) are dropped, lookups always complete.
//
// Ports: clk/rst (async active-high); lk_valid/lk_pc lookup request; pred_valid/pred_hit/pred_taken/pred_target
// registered prediction; upd_valid/upd_pc/upd_taken/upd_target resolved-branch update; flush pulse / flush_busy status.
module btb_assoc_ctrl #(
  parameter int SETS = 16,
  parameter int WAYS = 4,
  parameter int CTRW = 2,
  localparam int IDXW = $clog2(SETS),
  localparam int AGEW = $clog2(WAYS),
  localparam int TAGW = 32 - 2 - IDXW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lk_valid,
  input  logic [31:0] lk_pc,
  output logic        pred_valid,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        flush,
  output logic        flush_busy
);

  localparam logic [CTRW-1:0] CTR_RST   = {1'b0, {(CTRW-1){1'b1}}};  // weakly not-taken
  localparam logic [CTRW-1:0] CTR_ALLOC = {1'b1, {(CTRW-1){1'b0}}};  // weakly taken
  localparam logic [CTRW-1:0] CTR_MAX   = {CTRW{1'b1}};

  typedef enum logic {S_IDLE, S_FLUSH} state_t;
  state_t state, state_nxt;
  logic [IDXW-1:0] flush_cnt;

  logic            valid_q  [SETS][WAYS];
  logic [TAGW-1:0] tag_q    [SETS][WAYS];
  logic [31:0]     target_q [SETS][WAYS];
  logic [CTRW-1:0] ctr_q    [SETS][WAYS];
  logic [AGEW-1:0] age_q    [SETS][WAYS];

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lk_pc[1:0], upd_pc[1:0]};

  // ---------------- lookup ----------------
  logic [IDXW-1:0] lk_idx;
  logic [TAGW-1:0] lk_tag;
  logic            lk_hit;
  logic [AGEW-1:0] lk_way;
  assign lk_idx = lk_pc[IDXW+1:2];
  assign lk_tag = lk_pc[31:IDXW+2];

  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
        lk_hit = 1'b1;
        lk_way = AGEW'(w);
      end
    end
  end

  // Reads happen before this edge's writes, so a same-cycle update is not visible.
  logic lk_use;
  assign lk_use = lk_valid && lk_hit && (state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else begin
      pred_valid  <= lk_valid;
      pred_hit    <= lk_use;
      pred_taken  <= lk_use && ctr_q[lk_idx][lk_way][CTRW-1];
      pred_target <= lk_use ? target_q[lk_idx][lk_way] : 32'h0;
    end
  end

  // ---------------- update way selection ----------------
  logic [IDXW-1:0] upd_idx;
  logic [TAGW-1:0] upd_tag;
  logic            upd_hit, any_inv;
  logic [AGEW-1:0] hit_way, inv_way, lru_way, sel_way, touch_age;
  logic [CTRW-1:0] ctr_cur, ctr_nxt;
  logic            do_write;
  assign upd_idx = upd_pc[IDXW+1:2];
  assign upd_tag = upd_pc[31:IDXW+2];

  always_comb begin
    upd_hit = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    lru_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[upd_idx][w] && tag_q[upd_idx][w] == upd_tag) begin
        upd_hit = 1'b1;
        hit_way = AGEW'(w);
      end
      if (!valid_q[upd_idx][w] && !any_inv) begin
        any_inv = 1'b1;
        inv_way = AGEW'(w);
      end
      if (age_q[upd_idx][w] == AGEW'(WAYS-1)) lru_way = AGEW'(w);
    end
    sel_way   = upd_hit ? hit_way : (any_inv ? inv_way : lru_way);
    touch_age = age_q[upd_idx][sel_way];
    ctr_cur   = ctr_q[upd_idx][sel_way];
    if (upd_taken) ctr_nxt = (ctr_cur == CTR_MAX) ? ctr_cur : ctr_cur + 1'b1;
    else           ctr_nxt = (ctr_cur == '0)      ? ctr_cur : ctr_cur - 1'b1;
  end

  // Not-taken misses allocate nothing and leave LRU alone.
  assign do_write = (state == S_IDLE) && upd_valid && !flush && (upd_hit || upd_taken);

  // ---------------- storage ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w]  <= 1'b0;
          tag_q[s][w]    <= '0;
          target_q[s][w] <= '0;
          ctr_q[s][w]    <= CTR_RST;
          age_q[s][w]    <= AGEW'(w);
        end
      end
    end else if (state == S_FLUSH) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[flush_cnt][w] <= 1'b0;
        ctr_q[flush_cnt][w]   <= CTR_RST;
        age_q[flush_cnt][w]   <= AGEW'(w);
      end
    end else if (do_write) begin
      // LRU touch: chosen way becomes youngest, every younger way ages by one.
      for (int w = 0; w < WAYS; w++) begin
        if (AGEW'(w) == sel_way)                 age_q[upd_idx][w] <= '0;
        else if (age_q[upd_idx][w] < touch_age)  age_q[upd_idx][w] <= age_q[upd_idx][w] + 1'b1;
      end
      if (upd_hit) begin
        ctr_q[upd_idx][sel_way] <= ctr_nxt;
        if (upd_taken) target_q[upd_idx][sel_way] <= upd_target;
      end else begin
        valid_q[upd_idx][sel_way]  <= 1'b1;
        tag_q[upd_idx][sel_way]    <= upd_tag;
        target_q[upd_idx][sel_way] <= upd_target;
        ctr_q[upd_idx][sel_way]    <= CTR_ALLOC;
      end
    end
  end

  // ---------------- flush FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= (state == S_FLUSH) ? flush_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (flush) state_nxt = S_FLUSH;
      S_FLUSH: if (flush_cnt == IDXW'(SETS-1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    flush_busy = (state == S_FLUSH);
  end

endmodule

// File: tb/tb_btb_assoc_ctrl.sv
// Randomised plus directed bench for btb_assoc_ctrl against a recency-list reference model.
// Latency: each step drives inputs, advances one edge and checks the registered prediction.
// Backpressure: not applicable; model drops updates during flush like the design.
module tb_btb_assoc_ctrl;
  localparam int SETS = 16;
  localparam int WAYS = 4;
  localparam int CTRW = 2;
  localparam int IDXW = 4;
  localparam int CTR_MAXV = (1 << CTRW) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic        pred_valid, pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        flush;
  logic        flush_busy;

  btb_assoc_ctrl #(.SETS(SETS), .WAYS(WAYS), .CTRW(CTRW)) dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_pc(lk_pc),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .flush(flush), .flush_busy(flush_busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: per set a recency list (position 0 = most recent).
  bit          m_valid [SETS][WAYS];
  int unsigned m_tag   [SETS][WAYS];
  logic [31:0] m_tgt   [SETS][WAYS];
  int          m_ctr   [SETS][WAYS];
  int          m_rank  [SETS][WAYS];
  bit          m_busy;
  int          m_cnt;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % SETS);
  endfunction
  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> (IDXW + 2);
  endfunction

  function automatic void m_clear_set(input int s);
    for (int w = 0; w < WAYS; w++) begin
      m_valid[s][w] = 1'b0;
      m_ctr[s][w]   = (1 << (CTRW - 1)) - 1;
      m_rank[s][w]  = w;
    end
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < SETS; s++) m_clear_set(s);
    m_busy = 1'b0;
    m_cnt  = 0;
  endfunction

  function automatic void m_touch(input int s, input int k);
    int p;
    p = 0;
    for (int q = 0; q < WAYS; q++) if (m_rank[s][q] == k) p = q;
    for (int q = p; q > 0; q--) m_rank[s][q] = m_rank[s][q-1];
    m_rank[s][0] = k;
  endfunction

  function automatic int m_find(input logic [31:0] pc);
    int s;
    s = idx_of(pc);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == tag_of(pc)) return w;
    return -1;
  endfunction

  function automatic void m_update(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    int s, w;
    s = idx_of(pc);
    w = m_find(pc);
    if (w >= 0) begin
      if (tk) begin
        m_ctr[s][w] = (m_ctr[s][w] < CTR_MAXV) ? m_ctr[s][w] + 1 : CTR_MAXV;
        m_tgt[s][w] = tgt;
      end else begin
        m_ctr[s][w] = (m_ctr[s][w] > 0) ? m_ctr[s][w] - 1 : 0;
      end
      m_touch(s, w);
    end else if (tk) begin
      w = -1;
      for (int q = WAYS - 1; q >= 0; q--) if (!m_valid[s][q]) w = q;
      if (w < 0) w = m_rank[s][WAYS-1];
      m_valid[s][w] = 1'b1;
      m_tag[s][w]   = tag_of(pc);
      m_tgt[s][w]   = tgt;
      m_ctr[s][w]   = 1 << (CTRW - 1);
      m_touch(s, w);
    end
  endfunction

  task automatic step(input bit lkv, input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                      input bit ut, input logic [31:0] utgt, input bit fl);
    bit eh, et;
    logic [31:0] etg;
    int w;
    lk_valid = lkv; lk_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    flush = fl;
    eh = 1'b0; et = 1'b0; etg = 32'h0;
    if (lkv && !m_busy) begin
      w = m_find(lpc);
      if (w >= 0) begin
        eh  = 1'b1;
        et  = m_ctr[idx_of(lpc)][w] >= (1 << (CTRW - 1));
        etg = m_tgt[idx_of(lpc)][w];
      end
    end
    if (m_busy) begin
      m_clear_set(m_cnt);
      if (m_cnt == SETS - 1) m_busy = 1'b0;
      else m_cnt++;
    end else if (fl) begin
      m_busy = 1'b1;
      m_cnt  = 0;
    end else if (uv) begin
      m_update(upc, ut, utgt);
    end
    @(posedge clk);
    #1;
    chk("pred_valid", {31'b0, pred_valid}, {31'b0, lkv});
    if (lkv) begin
      chk("pred_hit", {31'b0, pred_hit}, {31'b0, eh});
      chk("pred_taken", {31'b0, pred_taken}, {31'b0, et});
      chk("pred_target", pred_target, etg);
    end
    chk("flush_busy", {31'b0, flush_busy}, {31'b0, m_busy});
    lk_valid = 1'b0; upd_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask
  task automatic update(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    step(1'b0, 32'h0, 1'b1, pc, tk, tgt, 1'b0);
  endtask

  function automatic logic [31:0] mkpc(input int tag, input int idx);
    return (32'(tag) << (IDXW + 2)) | (32'(idx) << 2);
  endfunction

  initial begin
    int busy_cycles;
    logic [31:0] pa, pb, pc_, pd, pe, pf, pg, pn, rpc;
    rst = 1'b1; lk_valid = 0; lk_pc = 0; upd_valid = 0; upd_pc = 0;
    upd_taken = 0; upd_target = 0; flush = 0;
    m_reset();
    #12;
    chk("rst_pred_valid", {31'b0, pred_valid}, 32'd0);
    chk("rst_pred_target", pred_target, 32'd0);
    chk("rst_flush_busy", {31'b0, flush_busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Cold miss, allocate, counter walk with clamp at zero.
    lookup(32'h0000_1000);
    update(32'h0000_1000, 1'b1, 32'h0000_2000);
    lookup(32'h0000_1000);
    chk("tp_hit_target", pred_target, 32'h0000_2000);
    chk("tp_hit_taken", {31'b0, pred_taken}, 32'd1);
    update(32'h0000_1000, 1'b0, 32'h0);
    update(32'h0000_1000, 1'b0, 32'h0);
    lookup(32'h0000_1000);
    chk("tp_nt_taken", {31'b0, pred_taken}, 32'd0);
    update(32'h0000_1000, 1'b0, 32'h0);
    update(32'h0000_1000, 1'b1, 32'h0000_3000);
    lookup(32'h0000_1000);
    chk("tp_clamp_taken", {31'b0, pred_taken}, 32'd0);

    // LRU replacement in set 3.
    pa = mkpc(1, 3); pb = mkpc(2, 3); pc_ = mkpc(3, 3); pd = mkpc(4, 3);
    pe = mkpc(5, 3); pf = mkpc(6, 3); pg = mkpc(7, 3);
    update(pa, 1, 32'hA0); update(pb, 1, 32'hB0); update(pc_, 1, 32'hC0); update(pd, 1, 32'hD0);
    update(pa, 1, 32'hA1); update(pe, 1, 32'hE0);
    lookup(pb);
    chk("tp_b_evicted", {31'b0, pred_hit}, 32'd0);
    lookup(pa); lookup(pc_); lookup(pd); lookup(pe);
    chk("tp_e_target", pred_target, 32'hE0);
    // Not-taken miss must not disturb recency: next victim stays C.
    update(pf, 0, 32'hF0);
    lookup(pf);
    update(pg, 1, 32'h70);
    lookup(pc_);
    chk("tp_c_evicted", {31'b0, pred_hit}, 32'd0);
    lookup(pg); lookup(pd);

    // Same-cycle lookup and allocate.
    pn = mkpc(9, 7);
    step(1'b1, pn, 1'b1, pn, 1'b1, 32'h5555, 1'b0);
    chk("tp_same_cycle_miss", {31'b0, pred_hit}, 32'd0);
    lookup(pn);
    chk("tp_same_cycle_next", pred_target, 32'h5555);

    // Flush with mid-sweep update and repeated flush request.
    for (int s = 0; s < 6; s++) update(mkpc(s + 20, s), 1, 32'(s * 16));
    step(1'b0, 32'h0, 1'b1, mkpc(30, 9), 1'b1, 32'h99, 1'b1);  // flush wins
    busy_cycles = 0;
    for (int i = 0; i < SETS + 3; i++) begin
      if (flush_busy) busy_cycles++;
      if (i == 4) step(1'b1, mkpc(20, 0), 1'b1, mkpc(31, 10), 1'b1, 32'h77, 1'b0);
      else if (i == 6) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      else step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    end
    chk("tp_flush_cycles", 32'(busy_cycles), 32'(SETS));
    for (int s = 0; s < 6; s++) lookup(mkpc(s + 20, s));
    lookup(mkpc(31, 10));
    chk("tp_mid_flush_upd_dropped", {31'b0, pred_hit}, 32'd0);
    lookup(mkpc(30, 9));

    // Randomised traffic over a small PC pool to force conflicts.
    for (int i = 0; i < 3000; i++) begin
      rpc = mkpc($urandom_range(0, 6), $urandom_range(0, 3));
      step($urandom_range(0, 1), mkpc($urandom_range(0, 6), $urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, rpc, $urandom_range(0, 2) != 0, $urandom,
           $urandom_range(0, 199) == 0);
    end

    // Reset in the middle of a sweep.
    update(mkpc(40, 2), 1, 32'h4242);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    while (m_busy) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    update(mkpc(40, 2), 1, 32'h4242);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    #2;
    chk("midflush_rst_busy", {31'b0, flush_busy}, 32'd0);
    chk("midflush_rst_pred", {31'b0, pred_valid}, 32'd0);
    m_reset();
    rst = 1'b0;
    lookup(mkpc(40, 2));
    update(mkpc(41, 2), 1, 32'h1234);
    lookup(mkpc(41, 2));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
